// File: rtl/controle_medida_hcsr04_pkg.sv
// State codes and default HC-SR04 timing constants shared by the measurement controller
// and the interface_hcsr04 top level.
package controle_medida_hcsr04_pkg;

  typedef enum logic [2:0] {
    Inicial = 3'd0,
    Prepara = 3'd1,
    Trigger = 3'd2,
    Espera  = 3'd3,
    Mede    = 3'd4,
    Aguarda = 3'd5,
    Final   = 3'd6,
    Erro    = 3'd7
  } estado_t;

  // Defaults for a 50 MHz clock.
  localparam int unsigned TTriggerDef  = 500;        // 10 us
  localparam int unsigned TEsperaDef   = 1_250_000;  // 25 ms
  localparam int unsigned TEchoMaxDef  = 1_900_000;  // 38 ms
  localparam int unsigned TFimDef      = 16;
  localparam int unsigned CwDef        = 21;

  // A measurement is in progress everywhere except the idle and terminal states.
  function automatic logic em_medida(estado_t e);
    return (e != Inicial) && (e != Final) && (e != Erro);
  endfunction

endpackage

// File: rtl/sincroniza_borda.sv
// Two-flop synchroniser for an asynchronous input plus a delay flop for edge detection.
module sincroniza_borda (
  input  logic clock,
  input  logic reset,
  input  logic d,
  output logic q,
  output logic sobe,
  output logic desce
);

  logic meta_q;
  logic sync_q;
  logic atraso_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      meta_q   <= 1'b0;
      sync_q   <= 1'b0;
      atraso_q <= 1'b0;
    end else begin
      meta_q   <= d;
      sync_q   <= meta_q;
      atraso_q <= sync_q;
    end
  end

  assign q     = sync_q;
  assign sobe  = sync_q & ~atraso_q;
  assign desce = ~sync_q & atraso_q;

endmodule

// File: rtl/controle_medida_hcsr04.sv
// Sequences one HC-SR04 measurement: clear, trigger, wait echo, forward echo to
// contador_cm, wait for its pronto, and report pronto or timeout.
module controle_medida_hcsr04
  import controle_medida_hcsr04_pkg::*;
#(
  parameter int unsigned T_TRIGGER  = TTriggerDef,
  parameter int unsigned T_ESPERA   = TEsperaDef,
  parameter int unsigned T_ECHO_MAX = TEchoMaxDef,
  parameter int unsigned T_FIM      = TFimDef,
  parameter int unsigned CW         = CwDef
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       medir,
  input  logic       echo,
  input  logic       fim_medida,
  output logic       trigger,
  output logic       zera,
  output logic       pulso,
  output logic       medindo,
  output logic       pronto,
  output logic       timeout,
  output logic [3:0] db_estado
);

  localparam logic [CW-1:0] LimTrigger = CW'(T_TRIGGER - 1);
  localparam logic [CW-1:0] LimEspera  = CW'(T_ESPERA - 1);
  localparam logic [CW-1:0] LimEcho    = CW'(T_ECHO_MAX - 1);
  localparam logic [CW-1:0] LimFim     = CW'(T_FIM - 1);

  estado_t       state_q, state_d;
  logic [CW-1:0] tmr_q;
  logic          echo_s;
  logic          sobe;
  logic          desce;

  sincroniza_borda u_sincroniza_borda (
    .clock (clock),
    .reset (reset),
    .d     (echo),
    .q     (echo_s),
    .sobe  (sobe),
    .desce (desce)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= Inicial;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= (state_d != state_q) ? '0 : tmr_q + CW'(1);
    end
  end

  // Edge events are tested before the timer limit so an edge wins a same-cycle tie.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      Inicial: if (medir) state_d = Prepara;
      Prepara: state_d = Trigger;
      Trigger: if (tmr_q == LimTrigger) state_d = Espera;
      Espera: begin
        if (sobe)                    state_d = Mede;
        else if (tmr_q == LimEspera) state_d = Erro;
      end
      Mede: begin
        if (desce)                 state_d = Aguarda;
        else if (tmr_q == LimEcho) state_d = Erro;
      end
      Aguarda: begin
        if (fim_medida)           state_d = Final;
        else if (tmr_q == LimFim) state_d = Erro;
      end
      Final:   state_d = Inicial;
      Erro:    state_d = Inicial;
      default: state_d = Inicial;
    endcase
  end

  always_comb begin
    trigger = (state_q == Trigger);
    zera    = (state_q == Prepara) || (state_q == Erro);
    pulso   = echo_s && (state_q == Mede);
    medindo = em_medida(state_q);
    pronto  = (state_q == Final);
    timeout = (state_q == Erro);
  end

  assign db_estado = {1'b0, state_q};

endmodule
